window3x3_gen: RTL and testbench
================================

// Module: window3x3_gen
// PURPOSE
//  Producer side of the 3x3 neighbourhood interface: turns a raster-order 24-bit RGB pixel
//  stream into a 9-tap window (D00..D22) for the per-pixel filter stages (enhancement etc.).
//  Two on-chip line buffers hold the previous two rows; a 3-deep column shift per row forms
//  the window. Only full interior windows are flagged valid (no border padding).
// PARAMETERS
//  IMG_W   640  pixels per line (>=3); sets line-buffer depth
//  IMG_H   480  lines per frame (>=3)
//  DW      24   pixel width, {R[23:16],G[15:8],B[7:0]}
// PORTS
//  CLK         in   1   clock, all logic on rising edge
//  RESET       in   1   synchronous reset, active-high
//  DIN_VALID   in   1   DIN carries a pixel this cycle (no backpressure; every valid is accepted)
//  DIN_SOF     in   1   qualified by DIN_VALID: this pixel is (row 0, col 0) of a new frame
//  DIN         in   DW  input pixel
//  D02OUT,D01OUT,D00OUT  out DW each  upper line (row r-2), cols c-2,c-1,c
//  D12OUT,D11OUT,D10OUT  out DW each  middle line (row r-1), cols c-2,c-1,c
//  D22OUT,D21OUT,D20OUT  out DW each  under line (row r), cols c-2,c-1,c
//  DOUT_VALID  out  1   window is a full interior window (centre = D11OUT at (r-1,c-1))
//  DOUT_EOF    out  1   with DOUT_VALID: last window of the frame
// BEHAVIOUR
//  Reset: all D**OUT=0, DOUT_VALID=0, DOUT_EOF=0, col=0, row=0. Line-buffer RAM not cleared
//   (contents unused until row>=2). Reset mid-frame discards the frame; next accepted pixel is (0,0).
//  Counters: col 0..IMG_W-1, row 0..IMG_H-1. Accepted pixel at col=IMG_W-1 -> col=0,row+1;
//   at (IMG_W-1,IMG_H-1) -> (0,0). DIN_SOF with DIN_VALID forces this pixel to (0,0)
//   (counters then advance from it), overriding any position; partial frame silently dropped.
//  Per accepted pixel at (r,c), read-before-write at address c:
//   top=LB2[c], mid=LB1[c]; write LB2[c]<=LB1[c], LB1[c]<=DIN.
//   Next edge: D?2<=D?1, D?1<=D?0; D00<=top, D10<=mid, D20<=DIN.
//  Latency: window containing pixel (r,c) appears on outputs 1 clock after DIN accepted.
//  DOUT_VALID registered: =1 one clock after accepting pixel with r>=2 AND c>=2, else 0.
//  DOUT_EOF registered: =1 exactly with the DOUT_VALID for pixel (IMG_W-1,IMG_H-1).
//  DIN_VALID=0: counters, LB and all D**OUT hold; DOUT_VALID=0, DOUT_EOF=0.
//  Gaps in DIN_VALID anywhere (mid-line, between lines) do not alter results.
//  Windows never straddle lines: columns c-2,c-1 at c>=2 are always from the same row.
//  Valid windows per frame = (IMG_W-2)*(IMG_H-2). No arithmetic; data passes bit-exact.
//  RESET has priority over DIN_VALID/DIN_SOF in the same cycle.
// TESTING  (IMG_W=4, IMG_H=4, DIN=r*256+c unless noted)
//  1 Reset held 3 clocks with DIN_VALID=1 -> all outputs 0, no DOUT_VALID; release, frame
//    with DIN_SOF on first pixel -> first DOUT_VALID 1 clk after pixel (2,2) with
//    D02..D00=000000,000001,000002; D12..D10=000100,000101,000102; D22..D20=000200,000201,000202.
//  2 Full frame continuous -> exactly 4 DOUT_VALID pulses, centres (1,1),(1,2),(2,1),(2,2);
//    DOUT_EOF only on the 4th (D20OUT=000303).
//  3 Same frame with DIN_VALID toggled 1/0 each clock plus 5-clk gap per line -> identical
//    window sequence to test 2; outputs hold during gaps.
//  4 Two back-to-back frames, frame 2 DIN=0xFF0000+r*256+c -> frame 2 windows contain only
//    0xFF.... values (no frame-1 leakage), 4 valid, counters wrap without SOF needed.
//  5 DIN_SOF asserted at frame-1 pixel (1,3) -> that pixel becomes (0,0); next DOUT_VALID
//    only after 10 more pixels ((2,2) of new frame), count of 4 windows for new frame.
//  6 RESET pulsed 1 clk at pixel (2,1) -> no DOUT_VALID until 10 further pixels accepted.

Source files
------------

// File: rtl/window3x3_gen.sv
`default_nettype none
// ============================================================================
//  Module   : window3x3_gen
//  Purpose  : Turns a raster-order pixel stream into a 3x3 neighbourhood
//             window using two line buffers and a 3-deep column shift.
//  Revision : 1.0 - initial release
// ============================================================================
module window3x3_gen #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int DW    = 24
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          DIN_VALID,
    input  logic          DIN_SOF,
    input  logic [DW-1:0] DIN,
    output logic [DW-1:0] D02OUT,
    output logic [DW-1:0] D01OUT,
    output logic [DW-1:0] D00OUT,
    output logic [DW-1:0] D12OUT,
    output logic [DW-1:0] D11OUT,
    output logic [DW-1:0] D10OUT,
    output logic [DW-1:0] D22OUT,
    output logic [DW-1:0] D21OUT,
    output logic [DW-1:0] D20OUT,
    output logic          DOUT_VALID,
    output logic          DOUT_EOF
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] c_col_last = CW'(IMG_W - 1);
    localparam logic [RW-1:0] c_row_last = RW'(IMG_H - 1);
    localparam logic [CW-1:0] c_col_two  = CW'(2);
    localparam logic [RW-1:0] c_row_two  = RW'(2);

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;

    // LB1 holds row r-1, LB2 holds row r-2; never cleared
    logic [DW-1:0] r_lb1 [0:IMG_W-1];
    logic [DW-1:0] r_lb2 [0:IMG_W-1];

    logic [DW-1:0] r_d02, r_d01, r_d00;
    logic [DW-1:0] r_d12, r_d11, r_d10;
    logic [DW-1:0] r_d22, r_d21, r_d20;
    logic          r_valid;
    logic          r_eof;

    logic [CW-1:0] w_col;
    logic [RW-1:0] w_row;
    logic [CW-1:0] w_col_nxt;
    logic [RW-1:0] w_row_nxt;
    logic [DW-1:0] w_top;
    logic [DW-1:0] w_mid;
    logic          w_interior;
    logic          w_last;

    // SOF overrides the tracked position for the current pixel
    always_comb begin
        w_col     = DIN_SOF ? '0 : r_col;
        w_row     = DIN_SOF ? '0 : r_row;
        w_col_nxt = w_col + CW'(1);
        w_row_nxt = w_row;
        if (w_col == c_col_last) begin
            w_col_nxt = '0;
            w_row_nxt = (w_row == c_row_last) ? '0 : w_row + RW'(1);
        end
        w_top      = r_lb2[w_col];
        w_mid      = r_lb1[w_col];
        w_interior = (w_row >= c_row_two) && (w_col >= c_col_two);
        w_last     = (w_row == c_row_last) && (w_col == c_col_last);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_col   <= '0;
            r_row   <= '0;
            r_d02   <= '0;
            r_d01   <= '0;
            r_d00   <= '0;
            r_d12   <= '0;
            r_d11   <= '0;
            r_d10   <= '0;
            r_d22   <= '0;
            r_d21   <= '0;
            r_d20   <= '0;
            r_valid <= 1'b0;
            r_eof   <= 1'b0;
        end else if (DIN_VALID) begin
            r_col   <= w_col_nxt;
            r_row   <= w_row_nxt;
            r_d02   <= r_d01;
            r_d01   <= r_d00;
            r_d00   <= w_top;
            r_d12   <= r_d11;
            r_d11   <= r_d10;
            r_d10   <= w_mid;
            r_d22   <= r_d21;
            r_d21   <= r_d20;
            r_d20   <= DIN;
            r_valid <= w_interior;
            r_eof   <= w_interior && w_last;
        end else begin
            r_valid <= 1'b0;
            r_eof   <= 1'b0;
        end
    end

    // Read-before-write: the old LB1 entry ages into LB2
    always_ff @(posedge CLK) begin
        if (!RESET && DIN_VALID) begin
            r_lb2[w_col] <= w_mid;
            r_lb1[w_col] <= DIN;
        end
    end

    assign D02OUT     = r_d02;
    assign D01OUT     = r_d01;
    assign D00OUT     = r_d00;
    assign D12OUT     = r_d12;
    assign D11OUT     = r_d11;
    assign D10OUT     = r_d10;
    assign D22OUT     = r_d22;
    assign D21OUT     = r_d21;
    assign D20OUT     = r_d20;
    assign DOUT_VALID = r_valid;
    assign DOUT_EOF   = r_eof;

endmodule
`default_nettype wire

// File: tb/tb_window3x3_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_window3x3_gen
//  Purpose  : Directed, table-driven bench for window3x3_gen on a 4x4 image.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_window3x3_gen;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        DIN_VALID;
    logic        DIN_SOF;
    logic [23:0] DIN;
    logic [23:0] D02OUT, D01OUT, D00OUT;
    logic [23:0] D12OUT, D11OUT, D10OUT;
    logic [23:0] D22OUT, D21OUT, D20OUT;
    logic        DOUT_VALID;
    logic        DOUT_EOF;
    logic [23:0] tap [9];

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic             sof;
        logic [23:0]      din;
        logic             exp_v;
        logic             exp_eof;
        logic [8:0][23:0] exp_d;
    } vec_t;

    always #5 CLK = ~CLK;

    window3x3_gen #(.IMG_W(4), .IMG_H(4), .DW(24)) dut (
        .CLK(CLK), .RESET(RESET), .DIN_VALID(DIN_VALID), .DIN_SOF(DIN_SOF), .DIN(DIN),
        .D02OUT(D02OUT), .D01OUT(D01OUT), .D00OUT(D00OUT),
        .D12OUT(D12OUT), .D11OUT(D11OUT), .D10OUT(D10OUT),
        .D22OUT(D22OUT), .D21OUT(D21OUT), .D20OUT(D20OUT),
        .DOUT_VALID(DOUT_VALID), .DOUT_EOF(DOUT_EOF)
    );

    always_comb begin
        tap[0] = D02OUT; tap[1] = D01OUT; tap[2] = D00OUT;
        tap[3] = D12OUT; tap[4] = D11OUT; tap[5] = D10OUT;
        tap[6] = D22OUT; tap[7] = D21OUT; tap[8] = D20OUT;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic s, input logic [23:0] d);
        DIN_VALID = v;
        DIN_SOF   = s;
        DIN       = d;
        @(posedge CLK);
        #1;
        DIN_VALID = 1'b0;
        DIN_SOF   = 1'b0;
    endtask

    task automatic check_zero(input string name);
        logic [23:0] acc;
        acc = '0;
        for (int i = 0; i < 9; i++) acc = acc | tap[i];
        chk({name, " taps"}, {8'h0, acc}, 32'h0);
        chk({name, " valid"}, {31'h0, DOUT_VALID}, 32'h0);
        chk({name, " eof"}, {31'h0, DOUT_EOF}, 32'h0);
    endtask

    task automatic check_hold(input string name, input logic [23:0] last_din);
        chk({name, " hold d20"}, {8'h0, D20OUT}, {8'h0, last_din});
        chk({name, " hold valid"}, {31'h0, DOUT_VALID}, 32'h0);
        chk({name, " hold eof"}, {31'h0, DOUT_EOF}, 32'h0);
    endtask

    // One 4x4 frame of pixels base + r*256 + c, every window checked
    task automatic run_frame(input string tname, input logic [23:0] base,
                             input logic sof_first, input logic gaps);
        vec_t vecs [16];
        int   n_valid;
        int   n_eof;
        int   r;
        int   c;
        for (int k = 0; k < 16; k++) begin
            r = k / 4;
            c = k % 4;
            vecs[k].sof     = sof_first && (k == 0);
            vecs[k].din     = base + 24'(r * 256 + c);
            vecs[k].exp_v   = (r >= 2) && (c >= 2);
            vecs[k].exp_eof = (r == 3) && (c == 3);
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    vecs[k].exp_d[i*3+j] = vecs[k].exp_v ?
                        base + 24'((r - 2 + i) * 256 + (c - 2 + j)) : 24'h0;
        end
        n_valid = 0;
        n_eof   = 0;
        for (int k = 0; k < 16; k++) begin
            drive(1'b1, vecs[k].sof, vecs[k].din);
            if (DOUT_VALID) n_valid++;
            if (DOUT_EOF) n_eof++;
            chk($sformatf("%s px%0d valid", tname, k), {31'h0, DOUT_VALID}, {31'h0, vecs[k].exp_v});
            chk($sformatf("%s px%0d eof", tname, k), {31'h0, DOUT_EOF}, {31'h0, vecs[k].exp_eof});
            chk($sformatf("%s px%0d d20", tname, k), {8'h0, D20OUT}, {8'h0, vecs[k].din});
            if (vecs[k].exp_v)
                for (int t = 0; t < 9; t++)
                    chk($sformatf("%s px%0d tap%0d", tname, k, t),
                        {8'h0, tap[t]}, {8'h0, vecs[k].exp_d[t]});
            if (gaps) begin
                drive(1'b0, 1'b0, 24'hDEAD00);
                check_hold($sformatf("%s gap%0d", tname, k), vecs[k].din);
                if (k % 4 == 3)
                    for (int g = 0; g < 5; g++) begin
                        drive(1'b0, 1'b0, 24'hBEEF00);
                        check_hold($sformatf("%s linegap%0d", tname, k), vecs[k].din);
                    end
            end
        end
        chk({tname, " window count"}, n_valid, 4);
        chk({tname, " eof count"}, n_eof, 1);
    endtask

    initial begin
        RESET     = 1'b1;
        DIN_VALID = 1'b1;
        DIN_SOF   = 1'b0;
        DIN       = 24'h123456;

        // Test 1: reset held with DIN_VALID asserted
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            #1;
            check_zero($sformatf("t1 reset%0d", i));
        end
        RESET     = 1'b0;
        DIN_VALID = 1'b0;
        run_frame("t1", 24'h000000, 1'b1, 1'b0);

        // Test 2: continuous frame, counters wrapped to (0,0) without SOF
        run_frame("t2", 24'h000000, 1'b0, 1'b0);

        // Test 3: valid toggled every clock plus per-line gaps
        run_frame("t3", 24'h000000, 1'b1, 1'b1);

        // Test 4: back-to-back frames, second one without SOF
        run_frame("t4a", 24'h000000, 1'b1, 1'b0);
        run_frame("t4b", 24'hFF0000, 1'b0, 1'b0);

        // Test 5: SOF arrives at pixel (1,3) of a partial frame
        for (int k = 0; k < 7; k++) begin
            drive(1'b1, k == 0, 24'h110000 + 24'((k / 4) * 256 + (k % 4)));
            chk($sformatf("t5 pre%0d valid", k), {31'h0, DOUT_VALID}, 32'h0);
        end
        run_frame("t5", 24'h220000, 1'b1, 1'b0);

        // Test 6: reset pulse where pixel (2,1) would be accepted
        for (int k = 0; k < 9; k++) begin
            drive(1'b1, k == 0, 24'h330000 + 24'((k / 4) * 256 + (k % 4)));
            chk($sformatf("t6 pre%0d valid", k), {31'h0, DOUT_VALID}, 32'h0);
        end
        RESET = 1'b1;
        drive(1'b1, 1'b0, 24'h330201);
        RESET = 1'b0;
        check_zero("t6 reset");
        run_frame("t6", 24'h440000, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
